dm_fetch_responder: RTL

//  Responder end of the core instruction-fetch interface for debug-module addresses.
//  The core issues fetches to the debug halt and exception addresses, which its

---
 rtl/dm_fetch_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dm_fetch_responder.sv
// Instruction-fetch responder for the debug halt/exception entry addresses.
// In-order responses RespLatency cycles after grant; tracks halt entry and exception count.
module dm_fetch_responder #(
  parameter int unsigned BaseAddr       = 32'd1,
  parameter int unsigned HaltOffset     = 32'd10,
  parameter int unsigned ExcOffset      = 32'd12,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        clear_i,
  output logic        halted_o,
  output logic [7:0]  exc_count_o,
  output logic [2:0]  outstanding_o
);

  typedef enum logic [1:0] {
    KIND_ERR  = 2'd0,
    KIND_HALT = 2'd1,
    KIND_EXC  = 2'd2
  } kind_e;

  localparam logic [31:0] HaltAddr = 32'(BaseAddr + HaltOffset);
  localparam logic [31:0] ExcAddr  = 32'(BaseAddr + ExcOffset);
  localparam logic [1:0]  LastIdx  = 2'(MaxOutstanding - 1);
  localparam logic [1:0]  InitCnt  = 2'(RespLatency - 1);
  localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);
  localparam logic [31:0] InstrJal    = 32'h0000_006F;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  if (HaltOffset == ExcOffset) begin : g_bad_offsets
    $error("dm_fetch_responder: HaltOffset and ExcOffset must differ");
  end
  if (RespLatency == 0 || RespLatency > 4) begin : g_bad_latency
    $error("dm_fetch_responder: RespLatency must be 1..4");
  end
  if (MaxOutstanding == 0 || MaxOutstanding > 4) begin : g_bad_outstanding
    $error("dm_fetch_responder: MaxOutstanding must be 1..4");
  end

  // Only the decoded kind is queued; data and error are rebuilt at retire.
  kind_e       r_kind [4];
  logic [1:0]  r_cd   [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_halted;
  logic [7:0]  r_exc_cnt;

  kind_e       w_new_kind;
  kind_e       w_head_kind;
  logic        w_retire;
  logic        w_gnt;
  logic [31:0] w_head_rdata;
  logic        w_head_err;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastIdx) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    w_new_kind = KIND_ERR;
    if (addr_i == HaltAddr) begin
      w_new_kind = KIND_HALT;
    end else if (addr_i == ExcAddr) begin
      w_new_kind = KIND_EXC;
    end
  end

  // All entries share one latency, so only the head can ever reach zero first.
  assign w_head_kind = r_kind[r_rd_ptr];
  assign w_retire    = (r_count != 3'd0) && (r_cd[r_rd_ptr] == 2'd0);
  assign w_gnt       = rst_ni && req_i && ((r_count < MaxOut) || w_retire);

  always_comb begin
    w_head_rdata = 32'h0;
    w_head_err   = 1'b1;
    case (w_head_kind)
      KIND_HALT: begin
        w_head_rdata = InstrJal;
        w_head_err   = 1'b0;
      end
      KIND_EXC: begin
        w_head_rdata = InstrEbreak;
        w_head_err   = 1'b0;
      end
      default: begin
        w_head_rdata = 32'h0;
        w_head_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        r_kind[i] <= KIND_ERR;
        r_cd[i]   <= 2'd0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_cd[i] != 2'd0) r_cd[i] <= r_cd[i] - 2'd1;
      end
      if (w_gnt) begin
        r_kind[r_wr_ptr] <= w_new_kind;
        r_cd[r_wr_ptr]   <= InitCnt;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_retire) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_gnt, w_retire})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
      r_halted  <= 1'b0;
      r_exc_cnt <= 8'h0;
    end else begin
      if (w_retire) begin
        r_rdata <= w_head_rdata;
        r_err   <= w_head_err;
      end
      if (clear_i) begin
        r_halted  <= 1'b0;
        r_exc_cnt <= 8'h0;
      end else if (w_retire) begin
        if (w_head_kind == KIND_HALT) r_halted <= 1'b1;
        if (w_head_kind == KIND_EXC && r_exc_cnt != 8'hFF) r_exc_cnt <= r_exc_cnt + 8'd1;
      end
    end
  end

  assign gnt_o         = w_gnt;
  assign rvalid_o      = w_retire;
  assign rdata_o       = w_retire ? w_head_rdata : r_rdata;
  assign err_o         = w_retire ? w_head_err : r_err;
  assign halted_o      = r_halted;
  assign exc_count_o   = r_exc_cnt;
  assign outstanding_o = r_count;

endmodule
